// File: rtl/lieat_idu_mdisp_pkg.sv
// Shared lieat definitions: register index width, channel indices and the
// outstanding-entry field layout {chan, rdwen, rd} packed from bit 0 upward.
package lieat_idu_mdisp_pkg;

    localparam int REG_IDX       = 5;
    localparam int CHAN_COMMON   = 0;
    localparam int CHAN_LONG0    = 1;

    localparam int ENT_RD_LSB    = 0;
    localparam int ENT_RDWEN_POS = REG_IDX;
    localparam int ENT_CHAN_LSB  = REG_IDX + 1;

    function automatic int ent_width(input int nch);
        return ENT_CHAN_LSB + nch + 1;
    endfunction

endpackage

// File: rtl/lieat_idu_mdisp_if.sv
// Decode-to-dispatch and writeback bundle; the dispatcher sits on the slave side.
interface lieat_idu_mdisp_if
    import lieat_idu_mdisp_pkg::*;
#(
    parameter int NCH = 2
);
    logic               id_i_valid;
    logic               id_i_ready;
    logic [NCH:0]       id_i_chan;
    logic               id_i_rs1en;
    logic               id_i_rs2en;
    logic               id_i_rdwen;
    logic [REG_IDX-1:0] id_i_rs1;
    logic [REG_IDX-1:0] id_i_rs2;
    logic [REG_IDX-1:0] id_i_rd;

    logic [NCH:0]       disp_o_valid;
    logic [NCH:0]       disp_o_ready;

    logic               wbck_ena;
    logic [REG_IDX-1:0] wbck_rd;
    logic [NCH:0]       wbck_chan;
    logic               wbck_rdwen;

    modport master (
        output id_i_valid, id_i_chan, id_i_rs1en, id_i_rs2en, id_i_rdwen,
               id_i_rs1, id_i_rs2, id_i_rd, disp_o_ready, wbck_ena,
        input  id_i_ready, disp_o_valid, wbck_rd, wbck_chan, wbck_rdwen
    );

    modport slave (
        input  id_i_valid, id_i_chan, id_i_rs1en, id_i_rs2en, id_i_rdwen,
               id_i_rs1, id_i_rs2, id_i_rd, disp_o_ready, wbck_ena,
        output id_i_ready, disp_o_valid, wbck_rd, wbck_chan, wbck_rdwen
    );

endinterface

// File: rtl/lieat_oitf_fifo.sv
// In-order outstanding-instruction FIFO with per-entry valid bits exposed for
// hazard compare. Flush overrides any same-cycle allocate or retire.
module lieat_oitf_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_i,
    input  logic [DW-1:0]             wdata_i,
    input  logic                      retire_i,
    input  logic                      flush_i,
    output logic [DEPTH-1:0]          vld_o,
    output logic [DEPTH-1:0][DW-1:0]  ent_o,
    output logic [DW-1:0]             head_o,
    output logic [AW-1:0]             rptr_o,
    output logic [AW:0]               cnt_o,
    output logic                      full_o,
    output logic                      empty_o
);
    logic [DEPTH-1:0][DW-1:0] ent_q;
    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]              cnt_q, cnt_d;
    logic                     do_alloc, do_retire;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign do_alloc  = alloc_i & ~flush_i;
    assign do_retire = retire_i & ~empty_o & ~flush_i;

    always_comb begin
        vld_d  = vld_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            vld_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // Clear before set: when full with bypass, both hit the same slot.
            if (do_retire) begin
                vld_d[rptr_q] = 1'b0;
                rptr_d        = rptr_q + AW'(1);
            end
            if (do_alloc) begin
                vld_d[wptr_q] = 1'b1;
                wptr_d        = wptr_q + AW'(1);
            end
            case ({do_alloc, do_retire})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q  <= '0;
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (do_alloc) ent_q[wptr_q] <= wdata_i;
        end
    end

    assign vld_o  = vld_q;
    assign ent_o  = ent_q;
    assign head_o = empty_o ? '0 : ent_q[rptr_q];
    assign rptr_o = rptr_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/lieat_idu_mdisp.sv
// Multi-channel dispatcher: hazard check against outstanding long ops and
// per-channel gating. Optional macro LIEAT_OITF_BYPASS_EN lets a retiring head free its slot early.
module lieat_idu_mdisp
    import lieat_idu_mdisp_pkg::*;
#(
    parameter  int NCH        = 2,
    parameter  int OITF_DEPTH = 4,
    localparam int AW         = $clog2(OITF_DEPTH),
    localparam int DW         = ENT_CHAN_LSB + NCH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    lieat_idu_mdisp_if.slave bus,
    input  logic             flush_req,
    output logic             disp_dep,
    output logic             oitf_full,
    output logic             longi_empty,
    output logic             chan_err,
    output logic [AW:0]      oitf_cnt
);
    logic [OITF_DEPTH-1:0]         ent_vld, skip, dep_hit;
    logic [OITF_DEPTH-1:0][DW-1:0] ent_dat;
    logic [DW-1:0]                 head_dat, wr_dat;
    logic [AW-1:0]                 rptr;
    logic                          fifo_full, fifo_empty, retire_now;
    logic                          long_req, full_eff, block, ready, alloc, onehot;

    assign retire_now = bus.wbck_ena & ~fifo_empty;
    assign long_req   = |bus.id_i_chan[NCH:CHAN_LONG0];
    assign onehot     = (bus.id_i_chan != '0) &&
                        ((bus.id_i_chan & (bus.id_i_chan - (NCH+1)'(1))) == '0);
    assign chan_err   = bus.id_i_valid & ~onehot;

`ifdef LIEAT_OITF_BYPASS_EN
    assign full_eff = fifo_full & ~retire_now;
    always_comb begin
        skip = '0;
        if (retire_now) skip[rptr] = 1'b1;
    end
`else
    assign full_eff = fifo_full;
    assign skip     = '0;
`endif

    always_comb begin
        dep_hit = '0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            dep_hit[i] = ent_vld[i] & ~skip[i] & ent_dat[i][ENT_RDWEN_POS] &
                ((bus.id_i_rs1en & (ent_dat[i][ENT_RD_LSB +: REG_IDX] == bus.id_i_rs1)) |
                 (bus.id_i_rs2en & (ent_dat[i][ENT_RD_LSB +: REG_IDX] == bus.id_i_rs2)) |
                 (bus.id_i_rdwen & (ent_dat[i][ENT_RD_LSB +: REG_IDX] == bus.id_i_rd)));
        end
    end

    assign disp_dep = |dep_hit;
    assign block    = disp_dep | (long_req & full_eff) | flush_req | chan_err;

    assign bus.disp_o_valid = {(NCH+1){bus.id_i_valid & ~block}} & bus.id_i_chan;
    assign ready            = (|(bus.id_i_chan & bus.disp_o_ready)) & ~block;
    assign bus.id_i_ready   = ready;
    assign alloc            = bus.id_i_valid & ready & long_req;

    assign wr_dat = {bus.id_i_chan, bus.id_i_rdwen, bus.id_i_rd};

    lieat_oitf_fifo #(
        .DEPTH (OITF_DEPTH),
        .DW    (DW)
    ) u_oitf (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc_i  (alloc),
        .wdata_i  (wr_dat),
        .retire_i (retire_now),
        .flush_i  (flush_req),
        .vld_o    (ent_vld),
        .ent_o    (ent_dat),
        .head_o   (head_dat),
        .rptr_o   (rptr),
        .cnt_o    (oitf_cnt),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign bus.wbck_rd    = head_dat[ENT_RD_LSB +: REG_IDX];
    assign bus.wbck_rdwen = head_dat[ENT_RDWEN_POS];
    assign bus.wbck_chan  = head_dat[ENT_CHAN_LSB +: NCH+1];
    assign oitf_full      = full_eff;
    assign longi_empty    = fifo_empty;

endmodule

// File: tb/tb_lieat_idu_mdisp.sv
// Directed bench for lieat_idu_mdisp (NCH=2, OITF_DEPTH=4): vector table plus
// hand-written wrap, simultaneous alloc/retire and async-reset sequences.
module tb_lieat_idu_mdisp;
    import lieat_idu_mdisp_pkg::*;

`ifdef LIEAT_OITF_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush_req;
    logic       disp_dep, oitf_full, longi_empty, chan_err;
    logic [2:0] oitf_cnt;

    int n_vec = 0;
    int n_err = 0;

    lieat_idu_mdisp_if #(.NCH(2)) bus ();

    lieat_idu_mdisp #(.NCH(2), .OITF_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .flush_req   (flush_req),
        .disp_dep    (disp_dep),
        .oitf_full   (oitf_full),
        .longi_empty (longi_empty),
        .chan_err    (chan_err),
        .oitf_cnt    (oitf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v, chan, rs1en, rs1, rs2en, rs2, rdwen, rd, rdy, wb, fl;
        int e_dv, e_irdy, e_dep, e_cerr, e_full, e_wbrd, e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int v, int chan, int rs1en, int rs1, int rs2en, int rs2,
                                int rdwen, int rd, int rdy, int wb, int fl,
                                int e_dv, int e_irdy, int e_dep, int e_cerr, int e_full,
                                int e_wbrd, int e_cnt);
        vec_t r;
        r.v = v; r.chan = chan; r.rs1en = rs1en; r.rs1 = rs1; r.rs2en = rs2en; r.rs2 = rs2;
        r.rdwen = rdwen; r.rd = rd; r.rdy = rdy; r.wb = wb; r.fl = fl;
        r.e_dv = e_dv; r.e_irdy = e_irdy; r.e_dep = e_dep; r.e_cerr = e_cerr;
        r.e_full = e_full; r.e_wbrd = e_wbrd; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_i_valid   = t.v[0];
        bus.id_i_chan    = 3'(t.chan);
        bus.id_i_rs1en   = t.rs1en[0];
        bus.id_i_rs1     = 5'(t.rs1);
        bus.id_i_rs2en   = t.rs2en[0];
        bus.id_i_rs2     = 5'(t.rs2);
        bus.id_i_rdwen   = t.rdwen[0];
        bus.id_i_rd      = 5'(t.rd);
        bus.disp_o_ready = 3'(t.rdy);
        bus.wbck_ena     = t.wb[0];
        flush_req        = t.fl[0];
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0,0,7,0,0, 0,0,0,0,0,0,0));
    endtask

    // One cycle of a long (chan 1) request with optional retire; checks head and post-edge count.
    task automatic cyc(input string nm, input int v, input int rd, input int wb,
                       input int e_wbrd, input int e_cnt);
        @(negedge clk);
        drive(mk(v,2,0,0,0,0,1,rd,7,wb,0, 0,0,0,0,0,0,0));
        #1;
        if (wb != 0) chk({nm, " wbck_rd"}, int'(bus.wbck_rd), e_wbrd);
        @(posedge clk); #1;
        chk({nm, " oitf_cnt"}, int'(oitf_cnt), e_cnt);
    endtask

    int q[$];

    initial begin
        // state-carrying table, row comments give the scenario
        vecs.push_back(mk(1,2, 0,0, 0,0, 1,5,  7,0,0, 2,1,0,0,0, 0,1));  // long rd=5
        vecs.push_back(mk(1,1, 1,5, 0,0, 0,0,  7,0,0, 0,0,1,0,0, 5,1));  // RAW on 5 held
        vecs.push_back(mk(1,1, 1,5, 0,0, 0,0,  7,1,0, BYP,BYP,1-BYP,0,0, 5,0));
        vecs.push_back(mk(1,1, 1,5, 0,0, 0,0,  7,0,0, 1,1,0,0,0, 0,0));  // released
        vecs.push_back(mk(1,6, 0,0, 0,0, 0,0,  7,0,0, 0,0,0,1,0, 0,0));  // two-hot
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0,  7,0,0, 0,0,0,1,0, 0,0));  // zero-hot
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,  7,1,0, 0,0,0,0,0, 0,0));  // retire on empty
        vecs.push_back(mk(1,4, 0,0, 0,0, 1,1,  7,0,0, 4,1,0,0,0, 0,1));  // fill 1..4
        vecs.push_back(mk(1,2, 0,0, 0,0, 1,2,  7,0,0, 2,1,0,0,0, 1,2));
        vecs.push_back(mk(1,4, 0,0, 0,0, 1,3,  7,0,0, 4,1,0,0,0, 1,3));
        vecs.push_back(mk(1,2, 0,0, 0,0, 1,4,  7,0,0, 2,1,0,0,0, 1,4));
        vecs.push_back(mk(1,4, 0,0, 0,0, 1,6,  7,0,0, 0,0,0,0,1, 1,4));  // fifth long blocked
        vecs.push_back(mk(1,1, 1,7, 0,0, 1,8,  7,0,0, 1,1,0,0,1, 1,4));  // chan0 still goes
        vecs.push_back(mk(1,1, 1,7, 0,0, 1,8,  6,0,0, 1,0,0,0,1, 1,4));  // chan0 not ready
        vecs.push_back(mk(1,2, 0,0, 0,0, 1,9,  7,1,0, 2*BYP,BYP,0,0,1-BYP, 1,3+BYP));
        vecs.push_back(mk(1,4, 0,0, 0,0, 1,10, 7,0,0, 4-4*BYP,1-BYP,0,0,BYP, 2,4));
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,  7,1,0, 0,0,0,0,1-BYP, 2,3));
        vecs.push_back(mk(1,2, 0,0, 0,0, 1,11, 7,0,1, 0,0,0,0,0, 3,0));  // flush with 3
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,  7,0,0, 0,0,0,0,0, 0,0));
        vecs.push_back(mk(1,2, 0,0, 0,0, 1,12, 7,0,0, 2,1,0,0,0, 0,1));
        vecs.push_back(mk(1,1, 0,0, 1,12,0,0,  7,0,0, 0,0,1,0,0, 12,1)); // rs2 hazard
        vecs.push_back(mk(1,1, 0,12,0,12,0,12, 7,0,0, 1,1,0,0,0, 12,1)); // enables off
        vecs.push_back(mk(1,4, 0,0, 0,0, 1,12, 7,0,0, 0,0,1,0,0, 12,1)); // WAW
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,  7,1,0, 0,0,0,0,0, 12,0));

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst oitf_cnt",    int'(oitf_cnt),       0);
        chk("rst longi_empty", int'(longi_empty),    1);
        chk("rst oitf_full",   int'(oitf_full),      0);
        chk("rst disp_dep",    int'(disp_dep),       0);
        chk("rst wbck_rd",     int'(bus.wbck_rd),    0);
        chk("rst wbck_chan",   int'(bus.wbck_chan),  0);
        chk("rst wbck_rdwen",  int'(bus.wbck_rdwen), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d disp_o_valid", i), int'(bus.disp_o_valid), vecs[i].e_dv);
            chk($sformatf("v%0d id_i_ready", i),   int'(bus.id_i_ready),   vecs[i].e_irdy);
            chk($sformatf("v%0d disp_dep", i),     int'(disp_dep),         vecs[i].e_dep);
            chk($sformatf("v%0d chan_err", i),     int'(chan_err),         vecs[i].e_cerr);
            chk($sformatf("v%0d oitf_full", i),    int'(oitf_full),        vecs[i].e_full);
            chk($sformatf("v%0d wbck_rd", i),      int'(bus.wbck_rd),      vecs[i].e_wbrd);
            @(posedge clk); #1;
            chk($sformatf("v%0d oitf_cnt", i),     int'(oitf_cnt),         vecs[i].e_cnt);
            chk($sformatf("v%0d longi_empty", i),  int'(longi_empty),      (vecs[i].e_cnt == 0) ? 1 : 0);
        end

        // eight alloc/retire pairs walk both pointers around twice
        for (int k = 0; k < 8; k++) begin
            cyc($sformatf("wrap%0d alloc", k),  1, 16 + k, 0, 0, 1);
            cyc($sformatf("wrap%0d retire", k), 0, 0, 1, 16 + k, 0);
        end

        // simultaneous alloc+retire keeps the count and preserves order
        cyc("sim pre0", 1, 24, 0, 0, 1); q.push_back(24);
        cyc("sim pre1", 1, 25, 0, 0, 2); q.push_back(25);
        for (int k = 0; k < 6; k++) begin
            q.push_back(26 + k);
            cyc($sformatf("sim%0d", k), 1, 26 + k, 1, q[0], 2);
            void'(q.pop_front());
        end
        cyc("sim drain0", 0, 0, 1, q[0], 1); void'(q.pop_front());
        cyc("sim drain1", 0, 0, 1, q[0], 0); void'(q.pop_front());

        // async reset mid-cycle drops entries without a clock edge
        cyc("ar fill0", 1, 3, 0, 0, 1);
        cyc("ar fill1", 1, 4, 0, 0, 2);
        idle();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst oitf_cnt",    int'(oitf_cnt),    0);
        chk("arst longi_empty", int'(longi_empty), 1);
        chk("arst wbck_rd",     int'(bus.wbck_rd), 0);
        chk("arst wbck_rdwen",  int'(bus.wbck_rdwen), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post rst alloc", 1, 7, 0, 0, 1);
        cyc("post rst retire", 0, 0, 1, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lieat_idu_mdisp.md
LIEAT_IDU_MDISP -- requirements
Module: lieat_idu_mdisp

Interface
REQ-001 SHALL expose parameter NCH, default 2: number of long-latency channels (1..4); channel 0 is the single-cycle common unit, so channel vectors are NCH+1 bits wide.
REQ-002 SHALL expose parameter OITF_DEPTH, default 4: outstanding-entry capacity (power of two, 2..16); AW = log2(OITF_DEPTH).
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = asserted).
REQ-005 id_i_valid / id_i_ready  in/out  1  decoded-instruction handshake.
REQ-006 id_i_chan  in  NCH+1  one-hot target channel.
REQ-007 id_i_rs1en, id_i_rs2en, id_i_rdwen  in  1  operand and destination enables.
REQ-008 id_i_rs1, id_i_rs2, id_i_rd  in  `REG_IDX  register indices.
REQ-009 disp_o_valid / disp_o_ready  out/in  NCH+1  per-channel dispatch handshake.
REQ-010 wbck_ena  in  1  retire the oldest long instruction.
REQ-011 wbck_rd, wbck_chan, wbck_rdwen  out  `REG_IDX, NCH+1, 1  head-entry fields.
REQ-012 flush_req  in  1  discard all outstanding entries and block dispatch.
REQ-013 disp_dep, oitf_full, longi_empty, chan_err  out  1  status; oitf_cnt  out  AW+1  occupancy.

Function
REQ-014 SHALL hold an in-order FIFO of OITF_DEPTH entries {rd, rdwen, chan}, with AW-bit read/write pointers wrapping modulo OITF_DEPTH and a registered occupancy counter.
REQ-015 disp_dep SHALL be 1 when any valid entry with rdwen=1 matches rs1 (rs1en=1), rs2 (rs2en=1) or rd (rdwen=1, WAW).
REQ-016 long = |id_i_chan[NCH:1]; block = disp_dep | (long & oitf_full) | flush_req | chan_err.
REQ-017 disp_o_valid[i] SHALL equal id_i_valid & id_i_chan[i] & ~block; id_i_ready SHALL equal |(id_i_chan & disp_o_ready) & ~block.
REQ-018 chan_err SHALL be id_i_valid & (id_i_chan not exactly one-hot); while set, no channel is valid and id_i_ready=0.
REQ-019 A completed handshake with long=1 SHALL write one entry at the write pointer and advance it in the same edge; channel-0 handshakes SHALL NOT allocate.
REQ-020 wbck_ena with longi_empty=0 SHALL pop the head; wbck_ena on empty SHALL be ignored with no pointer or count change.
REQ-021 Simultaneous allocate and retire SHALL leave oitf_cnt unchanged and move both pointers.
REQ-022 oitf_full = (oitf_cnt == OITF_DEPTH); longi_empty = (oitf_cnt == 0); both derived from registered state only.
REQ-023 flush_req SHALL zero both pointers and the count on the next edge, override any same-cycle allocate or retire, and force all disp_o_valid to 0 that cycle.
REQ-024 wbck_rd/wbck_chan/wbck_rdwen SHALL reflect the head entry combinationally, and read 0 when empty.

Reset
REQ-025 On reset=0: pointers, oitf_cnt and all entry valid bits 0; longi_empty=1, oitf_full=0, disp_dep=0, wbck_* outputs 0; reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro LIEAT_OITF_BYPASS_EN: when defined, a head entry retiring this cycle (wbck_ena=1) SHALL be excluded from dependency compare, and oitf_full SHALL ignore the slot being freed, allowing same-cycle retire+allocate when full; when undefined, both use registered state only (REQ-015, REQ-022).

Structure
REQ-027 `REG_IDX, channel-index constants and the entry field layout SHALL come from the shared lieat defines package; no local redefinition.
REQ-028 The FIFO storage and pointer logic SHALL be a sub-module lieat_oitf_fifo (params DEPTH, DW); hazard compare and dispatch gating stay in the top.

Verification
REQ-029 Dispatch chan=0b010 rd=5 rdwen=1, then chan=0b001 rs1=5 -> second held (disp_dep=1, id_i_ready=0) until wbck_ena retires, then dispatches on the following cycle.
REQ-030 Four long dispatches with OITF_DEPTH=4 -> oitf_full=1, oitf_cnt=4; fifth long blocked; channel-0 instruction with no hazard still dispatches.
REQ-031 Full FIFO plus same-cycle wbck_ena and long request -> blocked without LIEAT_OITF_BYPASS_EN, accepted with it (count stays 4).
REQ-032 flush_req with 3 entries and a pending long request -> no disp_o_valid, next cycle oitf_cnt=0 and longi_empty=1.
REQ-033 id_i_chan=0b110 or 0b000 with id_i_valid=1 -> chan_err=1, all disp_o_valid=0; wbck_ena on empty FIFO -> no state change.
REQ-034 Eight alloc/retire pairs with OITF_DEPTH=4 -> pointers wrap and wbck_rd returns rd values in dispatch order.
